// File: rtl/reg_mux_nx1_pkg.sv
// Shared constants and elaboration helpers for the registered N:1 mux.
package mux_pkg;

    localparam logic RR_MODE_EXPLICIT = 1'b0;
    localparam logic RR_MODE_RR       = 1'b1;
    localparam int   MAX_NUM_IN       = 16;

    // Index width for n channels, never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // (base + off) mod n, assuming base < n and off < n.
    function automatic int wrap_add(input int base, input int off, input int n);
        int s;
        s = base + off;
        if (s >= n) s -= n;
        return s;
    endfunction

endpackage

// File: rtl/reg_mux_nx1_if.sv
// Input channels, select controls and registered output of reg_mux_nx1.
interface reg_mux_nx1_if #(
    parameter int DATAWIDTH = 64,
    parameter int NUM_IN    = 4
);
    import mux_pkg::*;

    localparam int SELWIDTH = clog2(NUM_IN);

    logic [NUM_IN*DATAWIDTH-1:0] in_data;
    logic [NUM_IN-1:0]           in_valid;
    logic [NUM_IN-1:0]           in_ready;
    logic [SELWIDTH-1:0]         sel;
    logic                        rr_mode;
    logic [DATAWIDTH-1:0]        out_data;
    logic [SELWIDTH-1:0]         out_chan;
    logic                        out_valid;
    logic                        out_ready;

    modport master (
        output in_data, in_valid, sel, rr_mode, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, sel, rr_mode, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

endinterface

// File: rtl/reg_mux_nx1_rr_pick.sv
// Rotating-priority search: first valid channel at or after ptr, wrapping.
module rr_pick
    import mux_pkg::*;
#(
    parameter int NUM_IN   = 4,
    parameter int SELWIDTH = 2
) (
    input  logic [NUM_IN-1:0]   i_valid,
    input  logic [SELWIDTH-1:0] i_ptr,
    output logic [SELWIDTH-1:0] o_grant,
    output logic                o_found
);

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        o_grant = '0;
        o_found = 1'b0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (i_valid[wrap_add(int'(i_ptr), k, NUM_IN)]) begin
                o_grant = SELWIDTH'(wrap_add(int'(i_ptr), k, NUM_IN));
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_mux_nx1.sv
// N:1 valid/ready mux with one output register; explicit or round-robin select.
// Optional stall counter output enabled by REG_MUX_NX1_STALL_CNT_EN.
module reg_mux_nx1
    import mux_pkg::*;
#(
    parameter int DATAWIDTH = 64,
    parameter int NUM_IN    = 4
) (
    input  logic          Clk,
    input  logic          Rst,
    reg_mux_nx1_if.slave  bus
`ifdef REG_MUX_NX1_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    localparam int SELWIDTH = clog2(NUM_IN);
    localparam int SELSPAN  = 1 << SELWIDTH;

    logic [DATAWIDTH-1:0] r_out_data;
    logic [SELWIDTH-1:0]  r_out_chan;
    logic                 r_out_valid;
    logic [SELWIDTH-1:0]  r_ptr;

    logic [SELSPAN-1:0]   w_valid_pad;
    logic                 w_rr;
    logic                 w_load;
    logic                 w_exp_found;
    logic [SELWIDTH-1:0]  w_rr_grant;
    logic                 w_rr_found;
    logic [SELWIDTH-1:0]  w_grant;
    logic                 w_found;
    logic                 w_xfer;
    logic [NUM_IN-1:0]    w_in_ready;
    logic [DATAWIDTH-1:0] w_sel_data;
    logic [SELWIDTH-1:0]  w_ptr_next;

    // Zero-padding makes out-of-range explicit selects read as not valid.
    always_comb begin
        w_valid_pad               = '0;
        w_valid_pad[NUM_IN-1:0]   = bus.in_valid;
    end

    assign w_rr        = (bus.rr_mode == RR_MODE_RR);
    assign w_load      = !r_out_valid || bus.out_ready;
    assign w_exp_found = w_valid_pad[bus.sel];

    rr_pick #(
        .NUM_IN   (NUM_IN),
        .SELWIDTH (SELWIDTH)
    ) u_rr_pick (
        .i_valid (bus.in_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_rr_grant),
        .o_found (w_rr_found)
    );

    assign w_grant    = w_rr ? w_rr_grant : bus.sel;
    assign w_found    = w_rr ? w_rr_found : w_exp_found;
    assign w_xfer     = !Rst && w_load && w_found;
    assign w_ptr_next = SELWIDTH'(wrap_add(int'(w_grant), 1, NUM_IN));

    always_comb begin
        w_in_ready = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_grant == SELWIDTH'(i)) begin
                w_in_ready[i] = w_xfer;
                w_sel_data    = bus.in_data[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            r_out_data  <= w_sel_data;
            r_out_chan  <= w_grant;
            r_out_valid <= 1'b1;
            if (w_rr) r_ptr <= w_ptr_next;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_chan  = r_out_chan;
    assign bus.out_valid = r_out_valid;

`ifdef REG_MUX_NX1_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of cycles where the held word is refused downstream.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !bus.out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_reg_mux_nx1.sv
// Directed table-driven bench for reg_mux_nx1 (NUM_IN=4, DATAWIDTH=64).
module tb_reg_mux_nx1;

    localparam logic [63:0] D0 = 64'h1111_1111_0000_0000;
    localparam logic [63:0] D1 = 64'h2222_2222_0000_0001;
    localparam logic [63:0] D2 = 64'h0000_0000_DEAD_BEEF;
    localparam logic [63:0] D3 = 64'h4444_4444_0000_0003;

    logic Clk;
    logic Rst;
`ifdef REG_MUX_NX1_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    reg_mux_nx1_if #(.DATAWIDTH(64), .NUM_IN(4)) bus ();

    reg_mux_nx1 #(
        .DATAWIDTH (64),
        .NUM_IN    (4)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .bus       (bus)
`ifdef REG_MUX_NX1_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic        rst;
        logic        rr;
        logic [1:0]  sel;
        logic [3:0]  vld;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [1:0]  exp_chan;
        logic [63:0] exp_data;
        logic [15:0] exp_stall;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check in_ready, clock, then check the register.
    task automatic cycle(input string tag, input vec_t v);
        Rst           = v.rst;
        bus.rr_mode   = v.rr;
        bus.sel       = v.sel;
        bus.in_valid  = v.vld;
        bus.out_ready = v.ordy;
        #1;
        chk({tag, " in_ready"}, 64'(bus.in_ready), 64'(v.exp_rdy));
        @(posedge Clk);
        #1;
        chk({tag, " out_valid"}, 64'(bus.out_valid), 64'(v.exp_ov));
        chk({tag, " out_chan"}, 64'(bus.out_chan), 64'(v.exp_chan));
        chk({tag, " out_data"}, bus.out_data, v.exp_data);
`ifdef REG_MUX_NX1_STALL_CNT_EN
        chk({tag, " stall_cnt"}, 64'(stall_cnt), 64'(v.exp_stall));
`endif
    endtask

    initial begin
        Rst           = 1'b1;
        bus.in_data   = {D3, D2, D1, D0};
        bus.in_valid  = 4'b0000;
        bus.sel       = 2'd0;
        bus.rr_mode   = 1'b1;
        bus.out_ready = 1'b1;

        //                rst   rr    sel   vld    ordy  rdy    ov    chan  data  stall
        // Reset with every channel requesting.
        tbl.push_back('{1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 64'd0, 16'd0});
        tbl.push_back('{1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 64'd0, 16'd0});
        // Round-robin fairness, back-to-back.
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, D0,    16'd0});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, D1,    16'd0});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, D2,    16'd0});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, D3,    16'd0});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, D0,    16'd0});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, D1,    16'd0});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, D2,    16'd0});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, D3,    16'd0});
        // Explicit select; unselected valid channels must not be granted.
        tbl.push_back('{1'b0, 1'b0, 2'd2, 4'h4, 1'b1, 4'h4, 1'b1, 2'd2, D2,    16'd0});
        tbl.push_back('{1'b0, 1'b0, 2'd2, 4'hB, 1'b1, 4'h0, 1'b0, 2'd2, D2,    16'd0});
        tbl.push_back('{1'b0, 1'b0, 2'd3, 4'h8, 1'b1, 4'h8, 1'b1, 2'd3, D3,    16'd0});
        // Back to round-robin: ptr kept at 0, then skip to 1 and wrap through 3.
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'h4, 1'b1, 4'h4, 1'b1, 2'd2, D2,    16'd0});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'h2, 1'b1, 4'h2, 1'b1, 2'd1, D1,    16'd0});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'h9, 1'b1, 4'h8, 1'b1, 2'd3, D3,    16'd0});
        tbl.push_back('{1'b0, 1'b1, 2'd0, 4'h9, 1'b1, 4'h1, 1'b1, 2'd0, D0,    16'd0});

        for (int i = 0; i < tbl.size(); i++) begin
            cycle($sformatf("row%0d", i), tbl[i]);
        end

        // Backpressure: word from channel 0 held for 5 cycles, ptr sits at 1.
        for (int k = 0; k < 5; k++) begin
            cycle($sformatf("stall%0d", k),
                  '{1'b0, 1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, D0, 16'(k + 1)});
        end
        // Drain and reload in the same cycle keeps out_valid high.
        cycle("drain_load", '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, D1, 16'd5});

        // Reset while a stalled word is held; ptr must restart at 0.
        cycle("pre_rst",  '{1'b0, 1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1, D1,    16'd6});
        cycle("mid_rst",  '{1'b1, 1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0, 64'd0, 16'd0});
        cycle("post_rst", '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, D0,    16'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_mux_nx1.md
Name: reg_mux_nx1

Overview:
- Parametrised N:1 datapath multiplexer with a single registered output stage and valid/ready handshakes on every input channel and on the output.
- Channel selection has two modes: an explicit select port, or round-robin among valid channels.
- Successor to the combinational 2:1 mux. Used wherever several producers share one consumer, e.g. feeding a shared ALU or REG stage.

Parameters:
- DATAWIDTH, 64, bit width of each data channel.
- NUM_IN, 4, number of input channels (2..16).
- SELWIDTH, derived clog2(NUM_IN) (min 1), width of sel/out_chan. Localparam, not overridable.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  synchronous reset, active-high.
- in_data  input  NUM_IN*DATAWIDTH  packed channels; channel i at bits [i*DATAWIDTH +: DATAWIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready (combinational).
- sel  input  SELWIDTH  explicit channel select, used when rr_mode=0.
- rr_mode  input  1  1 = round-robin select, 0 = explicit select.
- out_data  output  DATAWIDTH  registered selected data.
- out_chan  output  SELWIDTH  channel index that out_data came from.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts when high.

Behaviour:
- Reset (Rst high at a rising edge): out_valid=0, out_data=0, out_chan=0, RR pointer=0. in_ready is all-zero while Rst is high. Reset mid-transfer discards the held word, and no input is accepted in that cycle.
- Load enable: load = !out_valid || out_ready. The register accepts a new word when it is empty or is being drained in the same cycle, so full throughput of 1 word/cycle is possible.
- Grant, explicit mode (rr_mode=0):
  - grant = sel when sel < NUM_IN and in_valid[sel]=1.
  - Otherwise there is no grant. sel >= NUM_IN never grants.
- Grant, round-robin mode (rr_mode=1):
  - grant = first i with in_valid[i]=1, searching ptr, ptr+1, ..., NUM_IN-1, 0, ..., ptr-1.
  - No valid channel means no grant.
- in_ready[i] = load && grant exists && i==grant, and Rst=0. At most one bit is set. in_ready does not depend on in_valid of non-granted channels beyond the grant search.
- Transfer on input i: in_valid[i] && in_ready[i]. At that edge:
  - out_data <= channel i, out_chan <= i, out_valid <= 1.
  - In rr_mode, ptr <= (i+1) mod NUM_IN, wrapping NUM_IN-1 to 0.
- Drain with no new grant: out_valid && out_ready && no transfer gives out_valid <= 0. out_data and out_chan hold their last values.
- Stall: out_valid && !out_ready holds out_data, out_chan and out_valid stable. All in_ready are 0.
- Latency: exactly 1 cycle from input handshake to out_valid.
- Mode switching: rr_mode and sel are sampled every cycle. ptr is retained while rr_mode=0 and resumes from its stored value.
- No internal FSM beyond the out_valid bit and ptr. No combinational path from in_data to out_data.

Optional Feature:
- Macro: REG_MUX_NX1_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0].
  - Increments by 1 on each cycle with out_valid && !out_ready.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by Rst.
  - Never wraps.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Shared package mux_pkg:
  - Constants RR_MODE_EXPLICIT=1'b0 and RR_MODE_RR=1'b1.
  - Function clog2 used for SELWIDTH.
  - Maximum NUM_IN constant = 16.
- One natural sub-module, rr_pick: combinational rotating priority search.
  - Inputs: valid vector, ptr.
  - Outputs: grant index, grant_found.
  - Instantiated once; the explicit path bypasses it.

Test Plan:
- Reset: assert Rst 2 cycles with all in_valid=4'b1111 → out_valid=0, out_data=0, out_chan=0, in_ready=4'b0000 throughout. First grant after release in rr_mode=1 is channel 0.
- Explicit mode: rr_mode=0, sel=2, in_valid=4'b0100, channel 2 data=64'hDEAD_BEEF, out_ready=1 → in_ready=4'b0100. Next cycle out_data=64'hDEAD_BEEF, out_chan=2, out_valid=1. Then sel=2 with in_valid[2]=0 → no transfer, and out_valid drops to 0 next cycle.
- Round-robin fairness: rr_mode=1, in_valid=4'b1111 held, out_ready=1 for 8 cycles → out_chan sequence 0,1,2,3,0,1,2,3 on consecutive cycles, out_valid continuously 1.
- Skip and wrap: rr_mode=1, ptr=3, in_valid=4'b0010 → grant channel 1, ptr becomes 2. Then in_valid=4'b1001 → grant channel 3, ptr wraps to 0.
- Backpressure: output full, out_ready=0 for 5 cycles with in_valid=4'b1111 → in_ready=0, out_data stable. With REG_MUX_NX1_STALL_CNT_EN, stall_cnt=5. Raising out_ready gives a drain and a new load in the same cycle, and out_valid stays 1.
- Reset mid-operation: out_valid=1 with out_ready=0, assert Rst 1 cycle → out_valid=0 next cycle, the held word is lost, and ptr=0.
